fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 81 ++++++++
 tb/tb_fetch_queue.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: PC-driven instruction fetch FIFO with a two-state fetch/stall controller
// Optional macro FETCH_BYPASS_EN: an accepted response reaching an empty queue is shown on the head outputs in the same cycle.
module fetch_queue #(
  parameter int          DEPTH_LOG2 = 2,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  rob_clear,
  input  logic [31:0]           back_pc,
  output logic                  start_fetch,
  output logic [31:0]           pc,
  input  logic                  instr_ready_in,
  input  logic [31:0]           instr_in,
  input  logic [31:0]           instr_addr_in,
  input  logic [31:0]           pred_pc_in,
  output logic                  instr_valid,
  output logic [31:0]           instr,
  output logic [31:0]           instr_addr,
  output logic [31:0]           instr_pred_pc,
  input  logic                  instr_issued,
  output logic [DEPTH_LOG2:0]   count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic {FETCH, STALL} state_t;
  state_t                state_q, state_d;
  logic                  start_q;
  logic [95:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_q, wr_q;
  logic [CW-1:0]         count_q, count_d;
  logic [31:0]           pc_q, pc_d;
  logic                  clr, acc, byp, push, pop, stored;
  // rdy low gates every state-changing event, so all registers hold
  assign clr    = rdy & rob_clear;
  assign acc    = rdy & ~rob_clear & instr_ready_in & start_q & (instr_addr_in == pc_q);
  assign stored = count_q != '0;
`ifdef FETCH_BYPASS_EN
  assign byp    = ~stored & acc;
`else
  assign byp    = 1'b0;
`endif
  // a bypassed response consumed in the same cycle never needs a slot
  assign push   = acc & ~(byp & instr_issued);
  assign pop    = rdy & ~rob_clear & instr_issued & stored;
  // next occupancy, fetch PC and fetch state
  always_comb begin
    count_d = clr ? '0 : (push & ~pop) ? count_q + CW'(1) : (pop & ~push) ? count_q - CW'(1) : count_q;
    pc_d    = clr ? back_pc : acc ? pred_pc_in : pc_q;
    state_d = (count_d == FULL) ? STALL : FETCH;
  end
  // control registers: pointers, occupancy, PC and fetch FSM with registered start_fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      pc_q    <= RESET_PC;
      state_q <= FETCH;
      start_q <= 1'b1;
    end else begin
      rd_q    <= clr ? '0 : pop ? rd_q + DEPTH_LOG2'(1) : rd_q;
      wr_q    <= clr ? '0 : push ? wr_q + DEPTH_LOG2'(1) : wr_q;
      count_q <= count_d;
      pc_q    <= pc_d;
      state_q <= state_d;
      start_q <= state_d == FETCH;
    end
  end
  // entry storage; contents are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {instr_in, instr_addr_in, pred_pc_in};
  end
  assign start_fetch = start_q;
  assign pc          = pc_q;
  assign count       = count_q;
  assign instr_valid = stored | byp;
  assign {instr, instr_addr, instr_pred_pc} = stored ? mem_q[rd_q] : byp ? {instr_in, instr_addr_in, pred_pc_in} : 96'd0;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue ordering, stall, flush, hold and reset behaviour
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        rob_clear = 1'b0;
  logic [31:0] back_pc = '0;
  logic        start_fetch;
  logic [31:0] pc;
  logic        instr_ready_in = 1'b0;
  logic [31:0] instr_in = '0;
  logic [31:0] instr_addr_in = '0;
  logic [31:0] pred_pc_in = '0;
  logic        instr_valid;
  logic [31:0] instr, instr_addr, instr_pred_pc;
  logic        instr_issued = 1'b0;
  logic [2:0]  count;
  int          checks = 0;
  int          errors = 0;

  fetch_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rob_clear(rob_clear), .back_pc(back_pc),
    .start_fetch(start_fetch), .pc(pc), .instr_ready_in(instr_ready_in),
    .instr_in(instr_in), .instr_addr_in(instr_addr_in), .pred_pc_in(pred_pc_in),
    .instr_valid(instr_valid), .instr(instr), .instr_addr(instr_addr),
    .instr_pred_pc(instr_pred_pc), .instr_issued(instr_issued), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    instr_ready_in = 1'b0;
    instr_issued   = 1'b0;
    rob_clear      = 1'b0;
    #1;
  endtask

  task automatic resp(input logic [31:0] a, input logic [31:0] p, input logic iss);
    instr_ready_in = 1'b1;
    instr_addr_in  = a;
    instr_in       = 32'hA000_0000 | a;
    pred_pc_in     = p;
    instr_issued   = iss;
    step();
    clear_in();
  endtask

  task automatic issue();
    instr_issued = 1'b1;
    step();
    clear_in();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_pc", pc, 32'h0);
    chk("rst_start", {31'd0, start_fetch}, 32'd1);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_addr", instr_addr, 32'h0);
    chk("rst_pred", instr_pred_pc, 32'h0);
    instr_ready_in = 1'b1;
    instr_addr_in  = 32'h0;
    instr_in       = 32'h0050_0093;
    pred_pc_in     = 32'h4;
    step();
    clear_in();
    chk("first_valid", {31'd0, instr_valid}, 32'd1);
    chk("first_instr", instr, 32'h0050_0093);
    chk("first_addr", instr_addr, 32'h0);
    chk("first_pred", instr_pred_pc, 32'h4);
    chk("first_pc", pc, 32'h4);
    chk("first_count", {29'd0, count}, 32'd1);
    resp(32'h4, 32'h8, 1'b0);
    resp(32'h8, 32'hC, 1'b0);
    resp(32'hC, 32'h10, 1'b0);
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_start", {31'd0, start_fetch}, 32'd0);
    chk("full_pc", pc, 32'h10);
    resp(32'h10, 32'h14, 1'b0);
    chk("stall_drop_count", {29'd0, count}, 32'd4);
    chk("stall_drop_pc", pc, 32'h10);
    issue();
    chk("pop_count", {29'd0, count}, 32'd3);
    chk("pop_start", {31'd0, start_fetch}, 32'd1);
    chk("pop_head", instr_addr, 32'h4);
    resp(32'h10, 32'h14, 1'b1);
    chk("pushpop_count", {29'd0, count}, 32'd3);
    chk("pushpop_head", instr_addr, 32'h8);
    chk("pushpop_instr", instr, 32'hA000_0008);
    issue();
    chk("wrap_head12", instr_addr, 32'hC);
    issue();
    chk("wrap_head16", instr_addr, 32'h10);
    chk("wrap_instr16", instr, 32'hA000_0010);
    chk("wrap_pred16", instr_pred_pc, 32'h14);
    chk("wrap_count", {29'd0, count}, 32'd1);
    issue();
    chk("empty_valid", {31'd0, instr_valid}, 32'd0);
    chk("empty_instr", instr, 32'h0);
    issue();
    chk("empty_issue_count", {29'd0, count}, 32'd0);
    resp(32'h14, 32'h18, 1'b0);
    resp(32'h18, 32'h1C, 1'b0);
    resp(32'h1C, 32'h20, 1'b0);
    chk("preflush_count", {29'd0, count}, 32'd3);
    rob_clear      = 1'b1;
    back_pc        = 32'h100;
    instr_ready_in = 1'b1;
    instr_addr_in  = 32'h20;
    instr_in       = 32'hDEAD_BEEF;
    pred_pc_in     = 32'h24;
    step();
    clear_in();
    chk("flush_count", {29'd0, count}, 32'd0);
    chk("flush_pc", pc, 32'h100);
    chk("flush_valid", {31'd0, instr_valid}, 32'd0);
    resp(32'h10, 32'h14, 1'b0);
    chk("stale_count", {29'd0, count}, 32'd0);
    chk("stale_pc", pc, 32'h100);
    resp(32'h100, 32'h104, 1'b0);
    chk("redir_head", instr_addr, 32'h100);
    chk("redir_pc", pc, 32'h104);
    rdy            = 1'b0;
    instr_ready_in = 1'b1;
    instr_addr_in  = 32'h104;
    pred_pc_in     = 32'h108;
    instr_issued   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_count", {29'd0, count}, 32'd1);
      chk("hold_pc", pc, 32'h104);
      chk("hold_head", instr_addr, 32'h100);
    end
    clear_in();
    rob_clear = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    rdy = 1'b1;
    clear_in();
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_count", {29'd0, count}, 32'd0);
    chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
    instr_ready_in = 1'b1;
    instr_addr_in  = 32'h0;
    instr_in       = 32'h13;
    pred_pc_in     = 32'h4;
    instr_issued   = 1'b1;
    #1;
`ifdef FETCH_BYPASS_EN
    chk("byp_valid", {31'd0, instr_valid}, 32'd1);
    chk("byp_instr", instr, 32'h13);
    step();
    clear_in();
    chk("byp_count", {29'd0, count}, 32'd0);
`else
    chk("nobyp_valid", {31'd0, instr_valid}, 32'd0);
    step();
    clear_in();
    chk("nobyp_count", {29'd0, count}, 32'd1);
    chk("nobyp_instr", instr, 32'h13);
`endif
    chk("byp_pc", pc, 32'h4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
